vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator, successor to the fixed 640x480 controller. Runs on the system clock with a pixel-rate enable and generates pixel coordinates for the frame-buffer fetch. It also produces sync and blank signals delayed by a configurable number of pixels, so they align with the fetch/colour pipeline at the DAC pins. Adds programmable sync polarity, line/frame start strobes and an optional frame counter.

---
 rtl/vga_timing_gen.sv | 165 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: undelayed pixel coordinates plus pixel-delayed sync/blank.
// Optional frame counter is built only when VGA_FRAME_COUNT_EN is defined; otherwise frame_cnt is tied to 0.
module vga_timing_gen #(
    parameter int   HACTIVE    = 640,
    parameter int   HFP        = 16,
    parameter int   HSYN       = 96,
    parameter int   HBP        = 48,
    parameter int   VACTIVE    = 480,
    parameter int   VFP        = 10,
    parameter int   VSYN       = 2,
    parameter int   VBP        = 33,
    parameter logic HSYNC_POL  = 1'b0,
    parameter logic VSYNC_POL  = 1'b0,
    parameter int   PIPE_DEPTH = 2,
    parameter int   CW         = 10,
    parameter int   FW         = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          hsync,
    output logic          vsync,
    output logic          blank_b,
    output logic [FW-1:0] frame_cnt
);

    localparam int HTOTAL = HACTIVE + HFP + HSYN + HBP;
    localparam int VTOTAL = VACTIVE + VFP + VSYN + VBP;

    if ((HTOTAL - 1) >= (1 << CW) || (VTOTAL - 1) >= (1 << CW)) begin : g_bad_cw
        $error("vga_timing_gen: HTOTAL-1 or VTOTAL-1 does not fit in CW bits");
    end
    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_bad_depth
        $error("vga_timing_gen: PIPE_DEPTH must be in 1..8");
    end

    // Thresholds are one bit wider than the coordinates so HTOTAL == 2^CW cannot wrap.
    localparam logic [CW:0]   X_LAST   = (CW+1)'(HTOTAL - 1);
    localparam logic [CW:0]   X_ACT    = (CW+1)'(HACTIVE);
    localparam logic [CW:0]   X_HS_BEG = (CW+1)'(HACTIVE + HFP);
    localparam logic [CW:0]   X_HS_END = (CW+1)'(HACTIVE + HFP + HSYN);
    localparam logic [CW:0]   Y_LAST   = (CW+1)'(VTOTAL - 1);
    localparam logic [CW:0]   Y_ACT    = (CW+1)'(VACTIVE);
    localparam logic [CW:0]   Y_VS_BEG = (CW+1)'(VACTIVE + VFP);
    localparam logic [CW:0]   Y_VS_END = (CW+1)'(VACTIVE + VFP + VSYN);
    localparam logic [CW-1:0] CW_ONE   = CW'(1'b1);

    logic [CW-1:0]         x_q, x_d;
    logic [CW-1:0]         y_q, y_d;
    logic [PIPE_DEPTH-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_DEPTH-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_DEPTH-1:0] bl_pipe_q, bl_pipe_d;
    logic [CW:0]           x_ext_s, y_ext_s;
    logic                  x_last_s, y_last_s;
    logic                  hs_raw_s, vs_raw_s, bl_raw_s;

    // Raw (undelayed) sync and blank decode from the current coordinates.
    always_comb begin
        x_ext_s  = {1'b0, x_q};
        y_ext_s  = {1'b0, y_q};
        x_last_s = (x_ext_s == X_LAST);
        y_last_s = (y_ext_s == Y_LAST);
        if ((x_ext_s >= X_HS_BEG) && (x_ext_s < X_HS_END)) begin
            hs_raw_s = HSYNC_POL;
        end else begin
            hs_raw_s = ~HSYNC_POL;
        end
        if ((y_ext_s >= Y_VS_BEG) && (y_ext_s < Y_VS_END)) begin
            vs_raw_s = VSYNC_POL;
        end else begin
            vs_raw_s = ~VSYNC_POL;
        end
        bl_raw_s = (x_ext_s < X_ACT) && (y_ext_s < Y_ACT);
    end

    // Next-state for the raster counters and the pixel-clocked delay line.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        hs_pipe_d = hs_pipe_q;
        vs_pipe_d = vs_pipe_q;
        bl_pipe_d = bl_pipe_q;
        if (pix_en) begin
            if (x_last_s) begin
                x_d = {CW{1'b0}};
                if (y_last_s) begin
                    y_d = {CW{1'b0}};
                end else begin
                    y_d = y_q + CW_ONE;
                end
            end else begin
                x_d = x_q + CW_ONE;
                y_d = y_q;
            end
            hs_pipe_d[0] = hs_raw_s;
            vs_pipe_d[0] = vs_raw_s;
            bl_pipe_d[0] = bl_raw_s;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                hs_pipe_d[i] = hs_pipe_q[i-1];
                vs_pipe_d[i] = vs_pipe_q[i-1];
                bl_pipe_d[i] = bl_pipe_q[i-1];
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // State registers; reset fills the delay line with inactive sync and blanked video.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q       <= {CW{1'b0}};
            y_q       <= {CW{1'b0}};
            hs_pipe_q <= {PIPE_DEPTH{~HSYNC_POL}};
            vs_pipe_q <= {PIPE_DEPTH{~VSYNC_POL}};
            bl_pipe_q <= {PIPE_DEPTH{1'b0}};
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
            bl_pipe_q <= bl_pipe_d;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;

    // Count completes on the last pixel of each frame.
    always_comb begin
        if (pix_en && x_last_s && y_last_s) begin
            frame_cnt_d = frame_cnt_q + FW'(1'b1);
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= {FW{1'b0}};
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = {FW{1'b0}};
`endif

    // Strobes are combinational so they coincide with the pixel they mark.
    assign line_start  = pix_en && (x_q == {CW{1'b0}});
    assign frame_start = line_start && (y_q == {CW{1'b0}});
    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hs_pipe_q[PIPE_DEPTH-1];
    assign vsync       = vs_pipe_q[PIPE_DEPTH-1];
    assign blank_b     = bl_pipe_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances (default and inverted polarity, different delays)
// compared every clock against a pixel-index model; frame_cnt expectation follows VGA_FRAME_COUNT_EN.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int CWT = 6;
    localparam int FWT = 2;
    localparam int PD0 = 2;
    localparam int PD1 = 3;

    logic clk = 1'b0;
    logic reset;
    logic pix_en;

    logic [CWT-1:0] x0, y0, x1, y1;
    logic ls0, fs0, hs0, vs0, bl0;
    logic ls1, fs1, hs1, vs1, bl1;
    logic [FWT-1:0] fc0, fc1;

    int n_total = 0;
    int n_pass  = 0;
    int p       = 0;
    int cyc     = 0;
    int fs_prev = 0;
    int fs_gap  = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .HACTIVE(HA), .HFP(HF), .HSYN(HS), .HBP(HB),
        .VACTIVE(VA), .VFP(VF), .VSYN(VS), .VBP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .PIPE_DEPTH(PD0), .CW(CWT), .FW(FWT)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0),
        .hsync(hs0), .vsync(vs0), .blank_b(bl0), .frame_cnt(fc0)
    );

    vga_timing_gen #(
        .HACTIVE(HA), .HFP(HF), .HSYN(HS), .HBP(HB),
        .VACTIVE(VA), .VFP(VF), .VSYN(VS), .VBP(VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .PIPE_DEPTH(PD1), .CW(CWT), .FW(FWT)
    ) dut_inv (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1),
        .hsync(hs1), .vsync(vs1), .blank_b(bl1), .frame_cnt(fc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (p=%0d)", tag, obs, exp, p);
    endtask

    // Delayed outputs at pixel index pp show the raw raster value from pixel pp-pd.
    task automatic delayed(input int pp, input int pd, input logic hpol, input logic vpol,
                           output logic ehs, output logic evs, output logic ebl);
        int q, qx, qy;
        if (pp < pd) begin
            ehs = ~hpol;
            evs = ~vpol;
            ebl = 1'b0;
        end else begin
            q   = pp - pd;
            qx  = q % HT;
            qy  = (q / HT) % VT;
            ehs = (qx >= HA + HF && qx < HA + HF + HS) ? hpol : ~hpol;
            evs = (qy >= VA + VF && qy < VA + VF + VS) ? vpol : ~vpol;
            ebl = (qx < HA) && (qy < VA);
        end
    endtask

    task automatic check_all();
        int ex, ey, efc;
        logic els, efs, ehs, evs, ebl;
        ex  = p % HT;
        ey  = (p / HT) % VT;
        els = pix_en && (ex == 0);
        efs = els && (ey == 0);
`ifdef VGA_FRAME_COUNT_EN
        efc = (p / FRAME) % (1 << FWT);
`else
        efc = 0;
`endif
        chk("x", 32'(x0), 32'(ex));
        chk("y", 32'(y0), 32'(ey));
        chk("line_start", 32'(ls0), 32'(els));
        chk("frame_start", 32'(fs0), 32'(efs));
        chk("frame_cnt", 32'(fc0), 32'(efc));
        delayed(p, PD0, 1'b0, 1'b0, ehs, evs, ebl);
        chk("hsync", 32'(hs0), 32'(ehs));
        chk("vsync", 32'(vs0), 32'(evs));
        chk("blank_b", 32'(bl0), 32'(ebl));
        chk("inv_x", 32'(x1), 32'(ex));
        chk("inv_y", 32'(y1), 32'(ey));
        chk("inv_frame_start", 32'(fs1), 32'(efs));
        chk("inv_line_start", 32'(ls1), 32'(els));
        chk("inv_frame_cnt", 32'(fc1), 32'(efc));
        delayed(p, PD1, 1'b1, 1'b1, ehs, evs, ebl);
        chk("inv_hsync", 32'(hs1), 32'(ehs));
        chk("inv_vsync", 32'(vs1), 32'(evs));
        chk("inv_blank_b", 32'(bl1), 32'(ebl));
    endtask

    // One clock: drive at negedge, check before posedge, advance the model at posedge.
    task automatic step(input logic en, input logic rst);
        pix_en = en;
        reset  = rst;
        #1;
        check_all();
        if (fs0 && pix_en) begin
            fs_gap  = cyc - fs_prev;
            fs_prev = cyc;
        end
        cyc++;
        @(posedge clk);
        if (rst) p = 0;
        else if (en) p++;
        @(negedge clk);
    endtask

    initial begin
        int guard;
        reset  = 1'b1;
        pix_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        p = 0;

        pix_en = 1'b1;
        reset  = 1'b0;
        #1;
        chk("rst_x", 32'(x0), 32'd0);
        chk("rst_y", 32'(y0), 32'd0);
        chk("rst_hsync", 32'(hs0), 32'd1);
        chk("rst_vsync", 32'(vs0), 32'd1);
        chk("rst_blank_b", 32'(bl0), 32'd0);
        chk("rst_frame_start", 32'(fs0), 32'd1);
        chk("rst_inv_hsync", 32'(hs1), 32'd0);

        for (int i = 0; i < 3 * FRAME; i++) step(1'b1, 1'b0);
        chk("fs_gap_en", 32'(fs_gap), 32'(FRAME));

        for (int i = 0; i < 6 * FRAME; i++) step((i % 2) == 0, 1'b0);
        chk("fs_gap_toggle", 32'(fs_gap), 32'(2 * FRAME));

        guard = 0;
        while (!(((p % HT) == 5) && (((p / HT) % VT) == 3)) && guard < 2 * FRAME) begin
            step(1'b1, 1'b0);
            guard++;
        end
        chk("mid_reached", 32'(guard < 2 * FRAME), 32'd1);
        step(1'b1, 1'b1);
        pix_en = 1'b1;
        reset  = 1'b0;
        #1;
        chk("mid_rst_x", 32'(x0), 32'd0);
        chk("mid_rst_y", 32'(y0), 32'd0);
        chk("mid_rst_blank_b", 32'(bl0), 32'd0);
        chk("mid_rst_frame_cnt", 32'(fc0), 32'd0);

        for (int i = 0; i < 5 * FRAME; i++) step(1'b1, 1'b0);
        pix_en = 1'b0;
        #1;
`ifdef VGA_FRAME_COUNT_EN
        chk("frame_cnt_5", 32'(fc0), 32'd1);
`else
        chk("frame_cnt_5", 32'(fc0), 32'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
